// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: registered grant, round-robin ties, bounded lock bursts.
// Define MEM_ARB_FIXED_PRIO_EN to make port 0 always win contention.
module mem_arbiter #(
  parameter int MAX_LOCK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] adr0,
  input  logic [31:0] adr1,
  input  logic [31:0] wd0,
  input  logic [31:0] wd1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] rd0,
  output logic [31:0] rd1,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] LMAX = 4'(MAX_LOCK - 1);

  state_t     state;
  state_t     nstate;
  logic [3:0] lcnt;
  logic [3:0] lcnt_n;
  logic       hold;
  logic       tie_p1;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign tie_p1 = 1'b0;
`else
  logic last;
  logic served;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
    end else if (state == OWN0) begin
      last <= 1'b0;
    end else if (state == OWN1) begin
      last <= 1'b1;
    end
  end

  // The cycle in progress already counts as served.
  always_comb begin
    served = last;
    if (state == OWN0) served = 1'b0;
    if (state == OWN1) served = 1'b1;
  end

  assign tie_p1 = ~served;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      lcnt  <= 4'd0;
    end else begin
      state <= nstate;
      lcnt  <= lcnt_n;
    end
  end

  assign hold = ((state == OWN0) & req0 & lock0)
              | ((state == OWN1) & req1 & lock1);

  always_comb begin
    nstate = IDLE;
    lcnt_n = 4'd0;
    if (hold && (lcnt < LMAX)) begin
      nstate = state;
      lcnt_n = lcnt + 4'd1;
    end else begin
      unique case (1'b1)
        (req0 & req1):  nstate = tie_p1 ? OWN1 : OWN0;
        (req0 & ~req1): nstate = OWN0;
        (~req0 & req1): nstate = OWN1;
        default:        nstate = IDLE;
      endcase
    end
  end

  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    unique case (state)
      OWN0: begin
        gnt0   = req0;
        mem_a  = adr0;
        mem_wd = wd0;
        mem_we = we0 & req0;
      end
      OWN1: begin
        gnt1   = req1;
        mem_a  = adr1;
        mem_wd = wd1;
        mem_we = we1 & req1;
      end
      default: ;
    endcase
  end

  assign rd0 = gnt0 ? mem_rd : '0;
  assign rd1 = gnt1 ? mem_rd : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random traffic
// against a cycle-level reference model of ownership, bursts and memory.
module tb_mem_arbiter;
  localparam int MAXL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic        req0, req1, lock0, lock1, we0, we1;
  logic [31:0] adr0, adr1, wd0, wd1;
  logic        gnt0, gnt1, mem_we;
  logic [31:0] rd0, rd1, mem_a, mem_wd, mem_rd;

  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];

  int checks = 0;
  int errors = 0;

  int m_owner;
  int m_last;
  int m_run;

  logic        e_g0, e_g1;
  logic        o_g0, o_g1;
  logic [31:0] o_rd0;
  logic [31:0] s0, s1;
  logic        pend0, pend1;

  mem_arbiter #(.MAX_LOCK(MAXL)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1),
    .adr0(adr0), .adr1(adr1),
    .wd0(wd0), .wd1(wd1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rd0(rd0), .rd1(rd1),
    .mem_we(mem_we), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[5:2]];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    end else if (mem_we) begin
      mem[mem_a[5:2]] <= mem_wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_run   = 0;
  endtask

  // Inputs are driven 1ns after the edge; check mid-cycle, advance model, clock.
  task automatic step();
    logic        ew;
    logic [31:0] ea, ewd, erd0, erd1;
    int          nxt;
    #4;
    if (reset) model_reset();
    e_g0 = (m_owner == 0) && req0;
    e_g1 = (m_owner == 1) && req1;
    ew = 1'b0; ea = '0; ewd = '0;
    if (m_owner == 0) begin
      ea = adr0; ewd = wd0; ew = we0 & req0;
    end else if (m_owner == 1) begin
      ea = adr1; ewd = wd1; ew = we1 & req1;
    end
    erd0 = e_g0 ? ref_mem[adr0[5:2]] : 32'h0;
    erd1 = e_g1 ? ref_mem[adr1[5:2]] : 32'h0;
    o_g0 = gnt0; o_g1 = gnt1; o_rd0 = rd0;
    chk("gnt0", {31'b0, gnt0}, {31'b0, e_g0});
    chk("gnt1", {31'b0, gnt1}, {31'b0, e_g1});
    chk("mem_we", {31'b0, mem_we}, {31'b0, ew});
    chk("mem_a", mem_a, ea);
    chk("mem_wd", mem_wd, ewd);
    chk("rd0", rd0, erd0);
    chk("rd1", rd1, erd1);
    if (!reset) begin
      if (ew) ref_mem[ea[5:2]] = ewd;
      if (m_owner >= 0) m_last = m_owner;
      if (m_owner >= 0 && m_run < MAXL &&
          ((m_owner == 0 && req0 && lock0) || (m_owner == 1 && req1 && lock1))) begin
        m_run++;
      end else begin
        if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
          nxt = 0;
`else
          nxt = 1 - m_last;
`endif
        end else if (req0) nxt = 0;
        else if (req1) nxt = 1;
        else nxt = -1;
        m_owner = nxt;
        m_run   = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
    adr0 = '0; adr1 = '0; wd0 = '0; wd1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    load  = 1'b1;
    idle_inputs();
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
    model_reset();
    @(posedge clk);
    #1;
    step();
    load = 1'b0;
    step();
    reset = 1'b0;

    // single requester reading word 2
    req0 = 1; adr0 = 32'h8;
    step();
    chk("single_idle_g0", {31'b0, o_g0}, 32'd0);
    step();
    chk("single_g0_c1", {31'b0, o_g0}, 32'd1);
    chk("single_rd_c1", o_rd0, 32'h1000_0002);
    step();
    chk("single_rd_c2", o_rd0, 32'h1000_0002);

    // contention without lock
    do_reset();
    req0 = 1; req1 = 1; adr0 = 32'h0; adr1 = 32'h4;
    step();
    s0 = '0; s1 = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      s0 = {s0[30:0], o_g0};
      s1 = {s1[30:0], o_g1};
    end
`ifdef MEM_ARB_FIXED_PRIO_EN
    chk("contend_g0", s0, 32'b111111);
    chk("contend_g1", s1, 32'b000000);
`else
    chk("contend_g0", s0, 32'b101010);
    chk("contend_g1", s1, 32'b010101);
`endif

    // lock bound: port 1 bursting while port 0 waits
    do_reset();
    req1 = 1; lock1 = 1; adr1 = 32'hC;
    step();
    req0 = 1; adr0 = 32'h14;
    s1 = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      s1 = {s1[30:0], o_g1};
    end
`ifdef MEM_ARB_FIXED_PRIO_EN
    chk("lock_g1", s1, 32'b111100);
`else
    chk("lock_g1", s1, 32'b111101);
`endif

    // write from port 1 then read back on port 0
    do_reset();
    req1 = 1; we1 = 1; adr1 = 32'h10; wd1 = 32'hDEAD_BEEF;
    step();
    step();
    chk("wr_g1", {31'b0, o_g1}, 32'd1);
    req1 = 0; we1 = 0;
    req0 = 1; adr0 = 32'h10;
    step();
    chk("drop_g1", {31'b0, o_g1}, 32'd0);
    step();
    chk("wr_rd0", o_rd0, 32'hDEAD_BEEF);

    // reset in the middle of a port-1 write
    do_reset();
    req1 = 1; we1 = 1; adr1 = 32'h20; wd1 = 32'h1234_5678;
    step();
    #4;
    chk("prerst_g1", {31'b0, gnt1}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_g1", {31'b0, gnt1}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_mem_word", mem[8], 32'h1000_0008);
    model_reset();
    idle_inputs();
    reset = 1'b0;

    // random traffic with occasional resets
    pend0 = 0; pend1 = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 249) == 0);
      if (!pend0) begin
        if ($urandom_range(0, 9) < 6) begin
          pend0 = 1; req0 = 1;
          we0  = 1'($urandom_range(0, 1));
          adr0 = 32'($urandom_range(0, 63));
          wd0  = $urandom;
        end else begin
          req0 = 0;
        end
      end
      if (!pend1) begin
        if ($urandom_range(0, 9) < 6) begin
          pend1 = 1; req1 = 1;
          we1  = 1'($urandom_range(0, 1));
          adr1 = 32'($urandom_range(0, 63));
          wd1  = $urandom;
        end else begin
          req1 = 0;
        end
      end
      lock0 = ($urandom_range(0, 2) == 0);
      lock1 = ($urandom_range(0, 2) == 0);
      step();
      if (e_g0) pend0 = 0;
      if (e_g1) pend1 = 0;
    end
    reset = 1'b0;
    idle_inputs();
    step();

    for (int i = 0; i < 16; i++) chk("mem_final", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-ported, word-addressed instruction/data memory between the multicycle RISC-V core (port 0) and a secondary master such as a program loader or DMA engine (port 1). Each access occupies exactly one memory cycle: combinational read, write committed on the rising clock edge. The arbiter registers its grant decision, supports short locked bursts for atomic sequences, and sits between the masters and `mem` inside `top`.

## Interface
- `MAX_LOCK`, default 4: maximum consecutive granted cycles a locking owner may hold the memory, range 1..15.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  access request from port 0 / port 1.
- `lock0`, `lock1`  in  1  keep ownership after the current access (burst/atomic).
- `we0`, `we1`  in  1  write enable for the request.
- `adr0`, `adr1`  in  32  byte address; bits [1:0] ignored by memory.
- `wd0`, `wd1`  in  32  write data.
- `gnt0`, `gnt1`  out  1  access performed this cycle; one-hot or zero.
- `rd0`, `rd1`  out  32  read data, `mem_rd` while the port is granted, else 0.
- `mem_we`  out  1  memory write enable.
- `mem_a`  out  32  memory address.
- `mem_wd`  out  32  memory write data.
- `mem_rd`  in  32  memory read data (combinational).

## Operation
- FSM states: IDLE, OWN0, OWN1. State, round-robin pointer `last` (last served port), and lock counter `lcnt` (4 bits) are registered.
- Outputs depend only on state and the owner's live inputs. In OWNx: `gntx`=`reqx`, `mem_a`=`adrx`, `mem_wd`=`wdx`, `mem_we`=`wex & reqx`. In IDLE all memory outputs are 0.
- Arbitration at each edge, computing next owner:
  - Current owner x with `reqx & lockx` and `lcnt < MAX_LOCK-1`: stay in OWNx, `lcnt`++.
  - Otherwise, only one port requesting: grant that port.
  - Both requesting: grant the port ≠ `last`.
  - Neither requesting: go to IDLE.
- On every change of owner, `lcnt` is cleared to 0. A cycle in OWNx counts as served (`last`=x).
- If the owner drops `req` while in OWNx, then `gntx`=0 and `mem_we`=0 that cycle. No write occurs, and re-arbitration occurs at the edge.
- A requester must hold `req`, `we`, `adr`, and `wd` stable until it samples `gnt`=1. Each `gnt` cycle completes exactly one access.

## Timing
- Reset (asynchronous, immediate): state IDLE, `last`=1 (port 0 wins the first tie), `lcnt`=0. `gnt0`=`gnt1`=0, `mem_we`=0, `mem_a`=0, `mem_wd`=0, `rd0`=`rd1`=0.
- Latency: `req` rising in cycle n gives `gnt` in cycle n+1 at the earliest. Read data is valid on `rdx` in the same cycle as `gntx`. A write lands at the edge ending the `gnt` cycle.
- A continuously requesting port without lock is served every cycle when alone, and every other cycle when contended.
- Owner switches directly between OWN0 and OWN1 with no IDLE bubble.
- A lock holds the memory for at most `MAX_LOCK` consecutive cycles. After that the other port, if requesting, is granted for at least one cycle.
- Reset asserted mid-burst aborts the grant immediately. A write in the cycle where reset rises is not committed, because `mem_we` drops asynchronously.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN` defined: the round-robin pointer is removed. On contention port 0 always wins. Locking and the `MAX_LOCK` bound still apply, so port 1 can still be granted once a port-0 burst expires only if port 0 is not requesting.
- Undefined (default): round-robin as above.

## Test plan
- Reset mid-operation: `reset` while OWN1 with `we1`=1 -> `gnt1` and `mem_we` go to 0 within the same cycle, and the memory word is unchanged.
- Single requester: `req0`=1, `we0`=0, `adr0`=0x8 for 3 cycles -> `gnt0`=1 from cycle 1 onward, and `rd0` = RAM[2] each granted cycle.
- Contention, round-robin: `req0`=`req1`=1, no lock, both held for 6 cycles -> grants alternate 0,1,0,1,0,1 starting with port 0 after reset.
- Lock bound, `MAX_LOCK`=4: port 1 locking while `req0` is held -> `gnt1` for 4 cycles, then `gnt0` for 1 cycle, then port 1 again.
- Write path: port 1 writes 0xDEADBEEF to 0x10, then port 0 reads 0x10 -> `rd0`=0xDEADBEEF on its grant cycle.
- With `MEM_ARB_FIXED_PRIO_EN`: both ports requesting for 5 cycles -> `gnt0` on all 5 and `gnt1` never.
